// File: rtl/vdp_pkg.sv
// Shared widths, FSM encoding and sample record for the Van der Pol sweep sequencer.
// Pure declarations: no logic, no latency, no flow control.
package vdp_pkg;

   localparam int Q_W    = 32;
   localparam int Q_FRAC = 16;
   localparam int IDX_W  = 16;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_WAIT  = 3'd2,
      S_STORE = 3'd3,
      S_STALL = 3'd4,
      S_DRAIN = 3'd5
   } state_t;

   typedef struct packed {
      logic [IDX_W-1:0] idx;
      logic [Q_W-1:0]   data;
   } sample_t;

endpackage

// File: rtl/vdp_seq_ctrl_if.sv
// Solver step bus plus sample stream between the sequencer (master) and its environment (slave).
// Stream transfers when out_valid and out_ready are both high; solver side is start/done.
interface vdp_seq_ctrl_if;
   import vdp_pkg::*;

   logic                  sol_start;
   logic signed [Q_W-1:0] sol_mu;
   logic signed [Q_W-1:0] sol_dt;
   logic signed [Q_W-1:0] sol_a;
   logic                  sol_done;
   logic signed [Q_W-1:0] sol_x;

   logic                  out_valid;
   logic                  out_ready;
   logic signed [Q_W-1:0] out_data;
   logic [IDX_W-1:0]      out_idx;

   modport master (
      output sol_start, sol_mu, sol_dt, sol_a,
      input  sol_done, sol_x,
      output out_valid, out_data, out_idx,
      input  out_ready
   );

   modport slave (
      input  sol_start, sol_mu, sol_dt, sol_a,
      output sol_done, sol_x,
      input  out_valid, out_data, out_idx,
      output out_ready
   );

endinterface

// File: rtl/vdp_sample_fifo.sv
// Synchronous sample FIFO (data + index), fall-through read, flags from extra-bit pointers.
// Push accepted when not full or when a pop happens in the same cycle; flush empties it.
module vdp_sample_fifo
   import vdp_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic    clk,
   input  logic    reset,
   input  logic    flush,
   input  logic    push,
   input  sample_t wr_dat,
   input  logic    pop,
   output sample_t rd_dat,
   output logic    full,
   output logic    empty
);
   localparam int             AW      = $clog2(DEPTH);
   localparam logic [AW:0]    PTR_ONE = {{AW{1'b0}}, 1'b1};

   sample_t     mem [DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic        do_push;
   logic        do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   // Head reads as zero when empty so the stream outputs are clean after reset/flush.
   assign rd_dat  = empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr[AW-1:0]] <= wr_dat;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

endmodule

// File: rtl/vdp_seq_ctrl.sv
// Van der Pol sweep sequencer: steps the solver n_iter times and streams every state sample.
// One step per ISSUE->WAIT->STORE round; a full sample FIFO parks the FSM in STALL until drained.
module vdp_seq_ctrl
   import vdp_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 1024
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  run,
   input  logic [IDX_W-1:0]      n_iter,
   input  logic signed [Q_W-1:0] mu_in,
   input  logic signed [Q_W-1:0] dt_in,
   input  logic signed [Q_W-1:0] a_in,
   output logic                  busy,
   output logic                  finished,
   output logic                  err_timeout,
   vdp_seq_ctrl_if.master        bus
);
   localparam int            TW       = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   state_t           state;
   logic             start_q;
   logic [Q_W-1:0]   mu_q;
   logic [Q_W-1:0]   dt_q;
   logic [Q_W-1:0]   a_q;
   logic [IDX_W-1:0] n_q;
   logic [IDX_W-1:0] cnt;
   logic [IDX_W-1:0] cnt_nxt;
   logic [TW-1:0]    tmo;
   sample_t          smp;
   sample_t          head;
   logic             fifo_full;
   logic             fifo_empty;
   logic             push_ok;
   logic             wait_hit;
   logic             tmo_hit;

   assign cnt_nxt  = cnt + IDX_W'(1);
   // tmo==0 marks the first WAIT cycle, where a done left over from the previous step is ignored.
   assign wait_hit = (state == S_WAIT) && (tmo != '0) && bus.sol_done;
   assign tmo_hit  = (state == S_WAIT) && !wait_hit && (tmo == TMO_LAST);
   assign push_ok  = ((state == S_STORE) || (state == S_STALL)) && (!fifo_full || bus.out_ready);

   vdp_sample_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk    (clk),
      .reset  (reset),
      .flush  (tmo_hit),
      .push   (push_ok),
      .wr_dat (smp),
      .pop    (bus.out_ready),
      .rd_dat (head),
      .full   (fifo_full),
      .empty  (fifo_empty)
   );

   assign bus.sol_start = start_q;
   assign bus.sol_mu    = mu_q;
   assign bus.sol_dt    = dt_q;
   assign bus.sol_a     = a_q;
   assign bus.out_valid = !fifo_empty;
   assign bus.out_data  = head.data;
   assign bus.out_idx   = head.idx;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= S_IDLE;
         start_q     <= 1'b0;
         busy        <= 1'b0;
         finished    <= 1'b0;
         err_timeout <= 1'b0;
         mu_q        <= '0;
         dt_q        <= '0;
         a_q         <= '0;
         n_q         <= '0;
         cnt         <= '0;
         tmo         <= '0;
         smp         <= '0;
      end else begin
         finished <= 1'b0;
         case (state)
            S_IDLE: begin
               if (run) begin
                  mu_q        <= mu_in;
                  dt_q        <= dt_in;
                  a_q         <= a_in;
                  n_q         <= n_iter;
                  cnt         <= '0;
                  err_timeout <= 1'b0;
                  if (n_iter == '0) begin
                     finished <= 1'b1;
                  end else begin
                     busy    <= 1'b1;
                     start_q <= 1'b1;
                     state   <= S_ISSUE;
                  end
               end
            end
            S_ISSUE: begin
               start_q <= 1'b0;
               tmo     <= '0;
               state   <= S_WAIT;
            end
            S_WAIT: begin
               if (wait_hit) begin
                  smp.idx  <= cnt;
                  smp.data <= bus.sol_x;
                  state    <= S_STORE;
               end else if (tmo_hit) begin
                  err_timeout <= 1'b1;
                  finished    <= 1'b1;
                  busy        <= 1'b0;
                  state       <= S_IDLE;
               end else begin
                  tmo <= tmo + TW'(1);
               end
            end
            S_STORE, S_STALL: begin
               if (push_ok) begin
                  cnt <= cnt_nxt;
                  if (cnt_nxt == n_q) begin
                     state <= S_DRAIN;
                  end else begin
                     start_q <= 1'b1;
                     state   <= S_ISSUE;
                  end
               end else begin
                  state <= S_STALL;
               end
            end
            S_DRAIN: begin
               if (fifo_empty) begin
                  finished <= 1'b1;
                  busy     <= 1'b0;
                  state    <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vdp_seq_ctrl.sv
// Directed bench for vdp_seq_ctrl: sweep, backpressure, zero length, timeout, stale done, mid-sweep reset.
// Inputs change 1 ns after the rising edge; the solver model and stream monitor act on the falling edge.
module tb_vdp_seq_ctrl;
   import vdp_pkg::*;

   localparam logic [31:0] MU      = 32'(2 << Q_FRAC);
   localparam logic [31:0] DT      = 32'(1 << (Q_FRAC - 1));
   localparam logic [31:0] A       = 32'(16 << Q_FRAC);
   localparam logic [31:0] X_STALE = 32'hDEAD_BEEF;
   localparam logic [31:0] X_NEW   = 32'h1234_5678;

   logic        clk    = 1'b0;
   logic        reset  = 1'b0;
   logic        run    = 1'b0;
   logic [15:0] n_iter = '0;
   logic [31:0] mu_in  = '0;
   logic [31:0] dt_in  = '0;
   logic [31:0] a_in   = '0;
   logic        busy;
   logic        finished;
   logic        err_timeout;

   vdp_seq_ctrl_if bus();

   vdp_seq_ctrl #(.FIFO_DEPTH(4), .TIMEOUT(16)) dut (
      .clk         (clk),
      .reset       (reset),
      .run         (run),
      .n_iter      (n_iter),
      .mu_in       (mu_in),
      .dt_in       (dt_in),
      .a_in        (a_in),
      .busy        (busy),
      .finished    (finished),
      .err_timeout (err_timeout),
      .bus         (bus)
   );

   always #5 clk = ~clk;

   int          n_chk    = 0;
   int          n_err    = 0;
   int          n_start  = 0;
   int          n_fin    = 0;
   int          got_n    = 0;
   int          sol_mode = 1;   // 0: done 5 cycles after start, 1: never done, 2: stale done
   int          cd       = 0;
   int          st       = 0;
   logic [31:0] got_dat [64];
   logic [15:0] got_idx [64];

   function automatic logic [31:0] xval(input int i);
      return 32'hA000_0000 + 32'(i * 7);
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic start_run(input logic [15:0] n);
      n_iter = n;
      mu_in  = MU;
      dt_in  = DT;
      a_in   = A;
      run    = 1'b1;
      tick(1);
      run    = 1'b0;
   endtask

   task automatic wait_fin(input string tag, input int budget, input int f0);
      int k;
      k = 0;
      while (n_fin == f0 && k < budget) begin
         tick(1);
         k++;
      end
      chk(tag, 32'(n_fin != f0), 32'd1);
   endtask

   // Solver model and stream/pulse monitor share one process so counts and done timing stay ordered.
   always @(negedge clk) begin
      if (finished) n_fin++;
      if (bus.out_valid && bus.out_ready && got_n < 64) begin
         got_dat[got_n] = bus.out_data;
         got_idx[got_n] = bus.out_idx;
         got_n++;
      end
      if (bus.sol_start) n_start++;
      case (sol_mode)
         0: begin
            st           = 0;
            bus.sol_done = 1'b0;
            if (cd > 0) begin
               cd--;
               if (cd == 0) begin
                  bus.sol_done = 1'b1;
                  bus.sol_x    = xval(n_start - 1);
               end
            end
            if (bus.sol_start) cd = 5;
         end
         2: begin
            cd = 0;
            case (st)
               0: begin
                  bus.sol_done = 1'b1;
                  bus.sol_x    = X_STALE;
                  if (bus.sol_start) st = 1;
               end
               1: st = 2;
               2: begin
                  bus.sol_x = X_NEW;
                  st        = 3;
               end
               default: bus.sol_done = 1'b0;
            endcase
         end
         default: begin
            st           = 0;
            cd           = 0;
            bus.sol_done = 1'b0;
            bus.sol_x    = '0;
         end
      endcase
   end

   initial begin
      #300000;
      $display("FAIL watchdog: run did not reach its summary");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int s0, f0, g0, k;
      bus.out_ready = 1'b0;

      // Reset state.
      #12;
      chk("rst_flags", {27'b0, busy, finished, err_timeout, bus.out_valid, bus.sol_start}, 32'd0);
      chk("rst_mu", bus.sol_mu, 32'd0);
      chk("rst_data", bus.out_data, 32'd0);
      chk("rst_idx", 32'(bus.out_idx), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      tick(2);

      // Nominal sweep of 8 steps with the stream always ready.
      sol_mode      = 0;
      bus.out_ready = 1'b1;
      tick(2);
      s0 = n_start; f0 = n_fin; g0 = got_n;
      start_run(16'd8);
      chk("sw_busy", 32'(busy), 32'd1);
      chk("sw_mu", bus.sol_mu, MU);
      chk("sw_dt", bus.sol_dt, DT);
      chk("sw_a", bus.sol_a, A);
      wait_fin("sw_fin", 200, f0);
      tick(3);
      chk("sw_starts", n_start - s0, 32'd8);
      chk("sw_fin_cnt", n_fin - f0, 32'd1);
      chk("sw_busy_end", 32'(busy), 32'd0);
      chk("sw_count", got_n - g0, 32'd8);
      for (int i = 0; i < 8; i++) begin
         chk("sw_idx", 32'(got_idx[g0 + i]), i);
         chk("sw_dat", got_dat[g0 + i], xval(s0 + i));
      end

      // Backpressure: FIFO fills with 4 samples, the 5th waits in STALL.
      bus.out_ready = 1'b0;
      s0 = n_start; f0 = n_fin; g0 = got_n;
      start_run(16'd10);
      k = 0;
      while (n_start - s0 < 5 && k < 200) begin
         tick(1);
         k++;
      end
      tick(12);
      chk("bp_starts", n_start - s0, 32'd5);
      tick(20);
      chk("bp_hold", n_start - s0, 32'd5);
      chk("bp_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_head", 32'(bus.out_idx), 32'd0);
      chk("bp_none", got_n - g0, 32'd0);
      chk("bp_busy", 32'(busy), 32'd1);
      bus.out_ready = 1'b1;
      wait_fin("bp_fin", 300, f0);
      tick(3);
      chk("bp_count", got_n - g0, 32'd10);
      for (int i = 0; i < 10; i++) begin
         chk("bp_idx", 32'(got_idx[g0 + i]), i);
         chk("bp_dat", got_dat[g0 + i], xval(s0 + i));
      end

      // Zero-length sweep.
      s0 = n_start;
      start_run(16'd0);
      chk("z_fin", 32'(finished), 32'd1);
      chk("z_valid", 32'(bus.out_valid), 32'd0);
      tick(1);
      chk("z_fin_off", 32'(finished), 32'd0);
      tick(5);
      chk("z_starts", n_start - s0, 32'd0);
      chk("z_busy", 32'(busy), 32'd0);
      chk("z_valid_end", 32'(bus.out_valid), 32'd0);

      // Solver timeout with TIMEOUT=16: err shows right after the 16th WAIT cycle.
      sol_mode = 1;
      tick(2);
      f0 = n_fin;
      start_run(16'd3);
      chk("to_start", 32'(bus.sol_start), 32'd1);
      tick(16);
      chk("to_early", 32'(err_timeout), 32'd0);
      tick(1);
      chk("to_err", 32'(err_timeout), 32'd1);
      chk("to_fin", 32'(finished), 32'd1);
      chk("to_busy", 32'(busy), 32'd0);
      tick(3);
      chk("to_sticky", 32'(err_timeout), 32'd1);
      chk("to_fin_cnt", n_fin - f0, 32'd1);
      start_run(16'd0);
      chk("to_clr", 32'(err_timeout), 32'd0);

      // Stale done held across the start cycle and first WAIT cycle.
      sol_mode = 2;
      tick(3);
      f0 = n_fin; g0 = got_n;
      start_run(16'd1);
      wait_fin("st_fin", 50, f0);
      tick(2);
      chk("st_count", got_n - g0, 32'd1);
      chk("st_dat", got_dat[g0], X_NEW);
      chk("st_idx", 32'(got_idx[g0]), 32'd0);
      chk("st_err", 32'(err_timeout), 32'd0);

      // Reset after 3 buffered samples, then a fresh sweep.
      sol_mode      = 0;
      bus.out_ready = 1'b0;
      tick(2);
      s0 = n_start; f0 = n_fin;
      start_run(16'd8);
      k = 0;
      while (n_start - s0 < 4 && k < 200) begin
         tick(1);
         k++;
      end
      chk("rm_valid", 32'(bus.out_valid), 32'd1);
      chk("rm_busy", 32'(busy), 32'd1);
      #2;
      reset = 1'b0;
      #1;
      chk("rm_flags", {27'b0, busy, finished, err_timeout, bus.out_valid, bus.sol_start}, 32'd0);
      chk("rm_mu", bus.sol_mu, 32'd0);
      chk("rm_data", bus.out_data, 32'd0);
      chk("rm_idx", 32'(bus.out_idx), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      tick(10);
      chk("rm_empty", 32'(bus.out_valid), 32'd0);
      chk("rm_nofin", n_fin - f0, 32'd0);
      bus.out_ready = 1'b1;
      s0 = n_start; f0 = n_fin; g0 = got_n;
      start_run(16'd2);
      wait_fin("rm_fin", 100, f0);
      tick(2);
      chk("rm_count", got_n - g0, 32'd2);
      for (int i = 0; i < 2; i++) begin
         chk("rm_idx2", 32'(got_idx[g0 + i]), i);
         chk("rm_dat2", got_dat[g0 + i], xval(s0 + i));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
